// File: rtl/wb_regfile_pkg.sv
// Shared constants and helpers for the write-back stage and register file.
// Holds the WB control-bus bit positions, default widths and the write-back data select.
package wb_regfile_pkg;

  localparam int REG_DATA_W  = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int REG_ZERO    = 0;

  // Bit positions inside the 2-bit WB control bus latched in MEM/WB
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  // Load data wins over the ALU result when MemToReg is set
  function automatic logic [REG_DATA_W-1:0] wb_select(
    input logic                  mem_to_reg,
    input logic [REG_DATA_W-1:0] alu_val,
    input logic [REG_DATA_W-1:0] mem_val
  );
    logic [REG_DATA_W-1:0] sel;
    if (mem_to_reg) begin
      sel = mem_val;
    end else begin
      sel = alu_val;
    end
    return sel;
  endfunction

endpackage

// File: rtl/wb_regfile_chk.sv
// Simulation-only checks for the write-back stage: RegWrite must be a known value
// whenever the block is out of reset.
module wb_regfile_chk (
  input logic clk,
  input logic reset,
  input logic reg_write
);

  // An X on RegWrite outside reset would make the commit decision unknown
  always @(posedge clk) begin
    if (!reset) begin
      a_regwrite_known: assert (!$isunknown(reg_write));
    end
  end

endmodule

// File: rtl/wb_regfile_core.sv
// GPR array: synchronous clear, one write port, N combinational read ports with
// write-through bypass, and a bypass-free debug read port. Entry 0 always reads as zero.
module regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int N_RD   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [N_RD-1:0][ADDR_W-1:0]  raddr,
  output logic [N_RD-1:0][DATA_W-1:0]  rdata,
  input  logic [ADDR_W-1:0]            dbg_addr,
  output logic [DATA_W-1:0]            dbg_data
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic              wr_ok_s;

  // Qualify the write so index 0 can never be committed, whatever the caller sends
  always_comb begin
    wr_ok_s = 1'b0;
    if (we && (waddr != ZERO_IDX)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Array update: clear has priority; an unknown enable only ever touches the addressed entry
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_r <= '{default: '0};
    end else if (wr_ok_s) begin
      regs_r[waddr] <= wdata;
    end else begin
      regs_r <= regs_r;
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    // One read port: zero register, then same-cycle bypass, then array contents
    always_comb begin
      rdata[p] = '0;
      if (raddr[p] == ZERO_IDX) begin
        rdata[p] = '0;
      end else if (wr_ok_s && (raddr[p] == waddr)) begin
        rdata[p] = wdata;
      end else begin
        rdata[p] = regs_r[raddr[p]];
      end
    end
  end

  // Debug port sees committed contents only, so a pending write shows up next cycle
  always_comb begin
    dbg_data = '0;
    if (dbg_addr == ZERO_IDX) begin
      dbg_data = '0;
    end else begin
      dbg_data = regs_r[dbg_addr];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: picks ALU or load data, qualifies the register write, commits it to
// the GPR array and exports the committed write to forwarding and the ID read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        WB_WB,
  input  logic [DATA_W-1:0] WB_ALUout,
  input  logic [DATA_W-1:0] WB_MEMout,
  input  logic [ADDR_W-1:0] WB_rd_or_rt,
  input  logic [ADDR_W-1:0] ID_rs,
  input  logic [ADDR_W-1:0] ID_rt,
  output logic [DATA_W-1:0] ID_rs_data,
  output logic [DATA_W-1:0] ID_rt_data,
  output logic              WB_we,
  output logic [ADDR_W-1:0] WB_waddr,
  output logic [DATA_W-1:0] WB_wdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic                      wb_we_s;
  logic [DATA_W-1:0]         wb_wdata_s;
  logic [1:0][ADDR_W-1:0]    raddr_s;
  logic [1:0][DATA_W-1:0]    rdata_s;

  // Write-back select and write qualification; reset suppresses the write and the bypass
  always_comb begin
    wb_wdata_s = wb_select(WB_WB[WB_MEMTOREG], WB_ALUout, WB_MEMout);
    wb_we_s    = 1'b0;
    if (WB_WB[WB_REGWRITE] && (WB_rd_or_rt != ADDR_W'(REG_ZERO)) && !reset) begin
      wb_we_s = 1'b1;
    end else begin
      wb_we_s = 1'b0;
    end
  end

  assign raddr_s    = {ID_rt, ID_rs};
  assign ID_rs_data = rdata_s[0];
  assign ID_rt_data = rdata_s[1];
  assign WB_we      = wb_we_s;
  assign WB_waddr   = WB_rd_or_rt;
  assign WB_wdata   = wb_wdata_s;

  regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .N_RD   (2)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .we       (wb_we_s),
    .waddr    (WB_rd_or_rt),
    .wdata    (wb_wdata_s),
    .raddr    (raddr_s),
    .rdata    (rdata_s),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  wb_regfile_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .reg_write (WB_WB[WB_REGWRITE])
  );

endmodule
